// File: rtl/demux_1x6_tdm_pkg.sv
// Shared constants for the 1-to-6 TDM demultiplexer.
// Optional frame-latch mode is selected by DEMUX_FRAME_LATCH_EN.
package demux_1x6_tdm_pkg;
    localparam int          NCH       = 6;
    localparam int          SLOT_W    = 3;
    localparam logic [2:0]  SLOT_LAST = 3'd5;
endpackage

// File: rtl/demux_1x6_tdm_if.sv
// Serial sample input and parallel channel output bundle of the TDM demux.
interface demux_1x6_tdm_if #(parameter int WIDTH = 1);
    import demux_1x6_tdm_pkg::*;

    logic [WIDTH-1:0]     din;
    logic                 din_valid;
    logic                 frame_sync;
    logic [NCH*WIDTH-1:0] y;
    logic [NCH-1:0]       y_valid;
    logic [SLOT_W-1:0]    slot;
    logic                 frame_done;
    logic                 sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  y, y_valid, slot, frame_done, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output y, y_valid, slot, frame_done, sync_err
    );
endinterface

// File: rtl/demux_1x6_tdm_slot_ctr.sv
// Mod-6 slot counter; a sync_load forces the current sample into slot 0.
module tdm_slot_ctr
    import demux_1x6_tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_i,
    input  logic              sync_load_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              is_last_o,
    output logic              misalign_o
);
    logic [SLOT_W-1:0] slot_q, slot_d, tgt;

    always_comb begin
        tgt    = sync_load_i ? '0 : slot_q;
        slot_d = slot_q;
        if (adv_i)
            slot_d = (tgt == SLOT_LAST) ? '0 : tgt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign slot_o     = slot_q;
    assign is_last_o  = adv_i && (tgt == SLOT_LAST);
    assign misalign_o = adv_i && sync_load_i && (slot_q != '0);
endmodule

// File: rtl/demux_1x6_tdm.sv
// Registered 1-to-6 TDM demultiplexer. With DEMUX_FRAME_LATCH_EN defined,
// samples fill a shadow bank and y updates once per completed frame.
module demux_1x6_tdm
    import demux_1x6_tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1x6_tdm_if.slave       bus
);
    logic              adv, sync_ld, is_last, misalign;
    logic [SLOT_W-1:0] slot, tgt;

    assign adv     = bus.din_valid;
    assign sync_ld = bus.din_valid & bus.frame_sync;

    tdm_slot_ctr u_ctr (
        .clk         (clk),
        .rst         (rst),
        .adv_i       (adv),
        .sync_load_i (sync_ld),
        .slot_o      (slot),
        .is_last_o   (is_last),
        .misalign_o  (misalign)
    );

    assign tgt = sync_ld ? '0 : slot;

    // bank_q is y itself in per-sample mode, the shadow bank in frame-latch mode
    logic [NCH-1:0][WIDTH-1:0] bank_q, bank_d;
    logic [NCH-1:0]            hot;
    logic [NCH-1:0]            yv_q;
    logic                      fd_q, se_q;

    always_comb begin
        hot    = '0;
        bank_d = bank_q;
        for (int k = 0; k < NCH; k++) begin
            if (adv && (tgt == SLOT_W'(k))) begin
                hot[k]    = 1'b1;
                bank_d[k] = bus.din;
            end
        end
    end

`ifdef DEMUX_FRAME_LATCH_EN
    logic [NCH-1:0][WIDTH-1:0] y_q;
    logic                      commit_q;

    // A frame commits only after its slot-5 write, so resync-abandoned frames never show
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q   <= '0;
            y_q      <= '0;
            commit_q <= 1'b0;
            yv_q     <= '0;
            fd_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            commit_q <= is_last;
            yv_q     <= commit_q ? '1 : '0;
            fd_q     <= commit_q;
            se_q     <= misalign;
            if (commit_q) y_q <= bank_q;
        end
    end

    assign bus.y = y_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
            yv_q   <= '0;
            fd_q   <= 1'b0;
            se_q   <= 1'b0;
        end else begin
            bank_q <= bank_d;
            yv_q   <= hot;
            fd_q   <= is_last;
            se_q   <= misalign;
        end
    end

    assign bus.y = bank_q;
`endif

    assign bus.y_valid    = yv_q;
    assign bus.slot       = slot;
    assign bus.frame_done = fd_q;
    assign bus.sync_err   = se_q;
endmodule

// File: tb/tb_demux_1x6_tdm.sv
// Self-checking bench for demux_1x6_tdm (WIDTH=1); expectations follow
// DEMUX_FRAME_LATCH_EN when the bench is built with it.
module tb_demux_1x6_tdm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_1x6_tdm_if #(.WIDTH(1)) bus ();
    demux_1x6_tdm #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [5:0] y;
        logic [5:0] yv;
        logic [2:0] slot;
        logic       fd;
        logic       se;
    } exp_t;

    typedef struct {
        logic din, v, fs;
        exp_t e;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   fd_cnt = 0;
    int   se_cnt = 0;
    exp_t sb[$];

    // reference model state
    logic [5:0] m_y, m_sh;
    int         m_slot;
    bit         m_commit;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_y = '0; m_sh = '0; m_slot = 0; m_commit = 0;
    endfunction

    function automatic exp_t model_step(input logic din, input logic v, input logic fs);
        exp_t e;
        int   t;
        e.yv = '0; e.fd = 0; e.se = 0;
`ifdef DEMUX_FRAME_LATCH_EN
        if (m_commit) begin
            m_y  = m_sh;
            e.yv = 6'h3f;
            e.fd = 1;
        end
        m_commit = 0;
        if (v) begin
            t = fs ? 0 : m_slot;
            e.se = fs && (m_slot != 0);
            m_sh[t] = din;
            m_commit = (t == 5);
            m_slot = (t == 5) ? 0 : t + 1;
        end
`else
        if (v) begin
            t = fs ? 0 : m_slot;
            e.se = fs && (m_slot != 0);
            m_y[t] = din;
            e.yv[t] = 1'b1;
            e.fd = (t == 5);
            m_slot = (t == 5) ? 0 : t + 1;
        end
`endif
        e.y = m_y;
        e.slot = 3'(m_slot);
        return e;
    endfunction

    task automatic drive(input logic din, input logic v, input logic fs, input exp_t e, input string nm);
        exp_t g;
        bus.din = din; bus.din_valid = v; bus.frame_sync = fs;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            chk({nm, ".sb_empty"}, 1, 0);
        end else begin
            g = sb.pop_front();
            chk({nm, ".y"},     32'(bus.y),          32'(g.y));
            chk({nm, ".yv"},    32'(bus.y_valid),    32'(g.yv));
            chk({nm, ".slot"},  32'(bus.slot),       32'(g.slot));
            chk({nm, ".fd"},    32'(bus.frame_done), 32'(g.fd));
            chk({nm, ".se"},    32'(bus.sync_err),   32'(g.se));
        end
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (bus.sync_err === 1'b1) se_cnt++;
    endtask

    task automatic run(input logic din, input logic v, input logic fs, input string nm);
        exp_t e;
        e = model_step(din, v, fs);
        drive(din, v, fs, e, nm);
    endtask

    task automatic do_reset();
        bus.din = 0; bus.din_valid = 0; bus.frame_sync = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        fd_cnt = 0; se_cnt = 0;
    endtask

    function automatic exp_t mk(input logic [5:0] y, input logic [5:0] yv, input logic [2:0] s,
                                input logic fd);
        exp_t e;
        e.y = y; e.yv = yv; e.slot = s; e.fd = fd; e.se = 0;
        return e;
    endfunction

    vec_t       ff[8];
    logic [5:0] pat;
    exp_t       dummy;

    initial begin
        bus.din = 0; bus.din_valid = 0; bus.frame_sync = 0;
        model_reset();
        pat = 6'b101101;

        // full frame: din 1,0,1,1,0,1 on ch0..5, then two idle cycles
`ifdef DEMUX_FRAME_LATCH_EN
        ff[0] = '{1, 1, 1, mk(6'h00, 6'h00, 3'd1, 0)};
        ff[1] = '{0, 1, 0, mk(6'h00, 6'h00, 3'd2, 0)};
        ff[2] = '{1, 1, 0, mk(6'h00, 6'h00, 3'd3, 0)};
        ff[3] = '{1, 1, 0, mk(6'h00, 6'h00, 3'd4, 0)};
        ff[4] = '{0, 1, 0, mk(6'h00, 6'h00, 3'd5, 0)};
        ff[5] = '{1, 1, 0, mk(6'h00, 6'h00, 3'd0, 0)};
        ff[6] = '{0, 0, 0, mk(6'h2d, 6'h3f, 3'd0, 1)};
        ff[7] = '{0, 0, 0, mk(6'h2d, 6'h00, 3'd0, 0)};
`else
        ff[0] = '{1, 1, 1, mk(6'h01, 6'h01, 3'd1, 0)};
        ff[1] = '{0, 1, 0, mk(6'h01, 6'h02, 3'd2, 0)};
        ff[2] = '{1, 1, 0, mk(6'h05, 6'h04, 3'd3, 0)};
        ff[3] = '{1, 1, 0, mk(6'h0d, 6'h08, 3'd4, 0)};
        ff[4] = '{0, 1, 0, mk(6'h0d, 6'h10, 3'd5, 0)};
        ff[5] = '{1, 1, 0, mk(6'h2d, 6'h20, 3'd0, 1)};
        ff[6] = '{0, 0, 0, mk(6'h2d, 6'h00, 3'd0, 0)};
        ff[7] = '{0, 0, 0, mk(6'h2d, 6'h00, 3'd0, 0)};
`endif

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.y",    32'(bus.y), 0);
        chk("rst.yv",   32'(bus.y_valid), 0);
        chk("rst.slot", 32'(bus.slot), 0);
        chk("rst.fd",   32'(bus.frame_done), 0);
        chk("rst.se",   32'(bus.sync_err), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            dummy = model_step(ff[i].din, ff[i].v, ff[i].fs);
            drive(ff[i].din, ff[i].v, ff[i].fs, ff[i].e, $sformatf("full[%0d]", i));
        end

        // same frame with idle gaps; final y must match the full-frame case
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run(pat[i], 1, i == 0, $sformatf("gap.s%0d", i));
            run(0, 0, 0, $sformatf("gap.i%0d", i));
        end
        run(0, 0, 0, "gap.tail");
        chk("gap.final_y", 32'(bus.y), 32'h2d);

        // mid-frame asynchronous reset, observed before the next edge
        run(1, 1, 1, "mid.s0");
        run(1, 1, 0, "mid.s1");
        run(1, 1, 0, "mid.s2");
        #2 rst = 1'b1;
        #1;
        chk("mid.y",    32'(bus.y), 0);
        chk("mid.yv",   32'(bus.y_valid), 0);
        chk("mid.slot", 32'(bus.slot), 0);
        @(posedge clk); #1;
        chk("mid.yv_hold", 32'(bus.y_valid), 0);
        rst = 1'b0;
        model_reset();
        fd_cnt = 0; se_cnt = 0;
        run(1, 1, 0, "mid.post");

        // misaligned sync after 3 samples
        do_reset();
        run(0, 1, 1, "mis.s0");
        run(0, 1, 0, "mis.s1");
        run(0, 1, 0, "mis.s2");
        run(1, 1, 1, "mis.resync");
        chk("mis.se_cnt", 32'(se_cnt), 1);
        chk("mis.slot1",  32'(bus.slot), 1);
        for (int i = 0; i < 4; i++) run(1, 1, 0, $sformatf("mis.f%0d", i));
        chk("mis.no_fd", 32'(fd_cnt), 0);
        run(0, 1, 0, "mis.last");
        run(0, 0, 0, "mis.idle");
        chk("mis.fd_cnt", 32'(fd_cnt), 1);
        chk("mis.se_once", 32'(se_cnt), 1);

        // back-to-back frames
        do_reset();
        for (int i = 0; i < 12; i++) run(1'($urandom_range(1)), 1, i == 0, $sformatf("b2b[%0d]", i));
        run(0, 0, 0, "b2b.i0");
        run(0, 0, 0, "b2b.i1");
        chk("b2b.fd_cnt", 32'(fd_cnt), 2);
        chk("b2b.se_cnt", 32'(se_cnt), 0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++)
            run(1'($urandom_range(1)), ($urandom_range(3) != 0), ($urandom_range(7) == 0), "rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
